ram_dma_ci: RTL and testbench

Custom-instruction (CI) block that couples a 512×32 local scratch memory with a bus-master DMA engine. The CPU reaches the memory and the DMA configuration registers through the CI port. The DMA engine moves blocks between the local memory and the shared system bus using burst transactions. It sits beside the CPU's CI decoder and acts as one master on the system bus.

---
 rtl/ram_dma_ci_if.sv | 36 +++
 rtl/ram_dma_ci.sv | 187 ++++++++++++++++++
 tb/tb_ram_dma_ci.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dma_ci_if.sv
// CI port plus system-bus signals of the ram_dma_ci block.
// slave is the block's own view; master is the CPU/bus/arbiter side.
interface ram_dma_ci_if;
    logic        ciStart;
    logic [7:0]  ciN;
    logic [31:0] ciValueA, ciValueB;
    logic        ciDone;
    logic [31:0] ciResult;
    logic        requestTransaction, transactionGranted;
    logic        beginTransactionIn, endTransactionIn, readNotWriteIn;
    logic        dataValidIn, busyIn, busErrorIn;
    logic [31:0] addressDataIn;
    logic [3:0]  byteEnablesIn;
    logic [7:0]  burstSizeIn;
    logic        beginTransactionOut, endTransactionOut, readNotWriteOut, dataValidOut;
    logic [31:0] addressDataOut;
    logic [3:0]  byteEnablesOut;
    logic [7:0]  burstSizeOut;

    modport slave (
        input  ciStart, ciN, ciValueA, ciValueB, transactionGranted,
               beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn,
               busyIn, busErrorIn, addressDataIn, byteEnablesIn, burstSizeIn,
        output ciDone, ciResult, requestTransaction,
               beginTransactionOut, endTransactionOut, readNotWriteOut, dataValidOut,
               addressDataOut, byteEnablesOut, burstSizeOut
    );
    modport master (
        output ciStart, ciN, ciValueA, ciValueB, transactionGranted,
               beginTransactionIn, endTransactionIn, readNotWriteIn, dataValidIn,
               busyIn, busErrorIn, addressDataIn, byteEnablesIn, burstSizeIn,
        input  ciDone, ciResult, requestTransaction,
               beginTransactionOut, endTransactionOut, readNotWriteOut, dataValidOut,
               addressDataOut, byteEnablesOut, burstSizeOut
    );
endinterface

// File: rtl/ram_dma_ci.sv
// 512x32 scratch RAM reachable over the CI port, with a burst DMA engine
// moving blocks between that RAM and the shared system bus.
module ram_dma_ci #(
    parameter logic [7:0] CUSTOM_ID = 8'd12
) (
    input logic          clock,
    input logic          reset,
    ram_dma_ci_if.slave  io
);
    typedef enum logic [2:0] {IDLE, REQUEST, INIT, READ_DATA, WRITE_DATA, WAIT_END, ERROR} state_t;

    state_t      state_q, state_d;
    logic [31:0] busAddr_q, curBus_q, curBus_d;
    logic [8:0]  memStart_q, curMem_q, curMem_d, words_q, words_d, cnt_q, cnt_d;
    logic [9:0]  blockSize_q, remain_q, remain_d;
    logic [7:0]  burst_q;
    logic        err_q, err_d, dirRd_q, dirRd_d, memRdPend_q;
    logic        beginOut_q, beginOut_d, endOut_q, endOut_d, rnwOut_q, rnwOut_d, dvOut_q, dvOut_d;
    logic [31:0] adOut_q, adOut_d;
    logic [3:0]  beOut_q, beOut_d;
    logic [7:0]  bsOut_q, bsOut_d;
    logic [31:0] ram [512];
    logic [31:0] ramA_q, ramB_q, regRd;
    logic [8:0]  bAddr, wordsNow, wm1;
    logic [9:0]  burstLen;
    logic        hit, we, busy, cfgWr, memWrA, memRdA, memWrB, start;
    logic [2:0]  sel;
    logic [8:0]  addrA;

    assign hit    = io.ciStart && (io.ciN == CUSTOM_ID);
    assign we     = io.ciValueA[9];
    assign sel    = io.ciValueA[12:10];
    assign addrA  = io.ciValueA[8:0];
    assign busy   = (state_q != IDLE);
    assign cfgWr  = hit && we && !busy;
    assign memWrA = hit && we && (sel == 3'd0);
    assign memRdA = hit && !we && (sel == 3'd0);
    assign start  = cfgWr && (sel == 3'd5) && (io.ciValueB[0] || io.ciValueB[1]);

    assign burstLen = {2'b00, burst_q} + 10'd1;
    assign wordsNow = (burstLen < remain_q) ? burstLen[8:0] : remain_q[8:0];
    assign wm1      = wordsNow - 9'd1;

    // Port B writes during bus->memory, otherwise prefetches the next outgoing word.
    assign bAddr = (state_q == READ_DATA) ? curMem_q : curMem_d;

    // CI port wins a same-address collision by writing last.
    always_ff @(posedge clock) begin
        if (memWrB) ram[bAddr] <= io.addressDataIn;
        if (memWrA) ram[addrA] <= io.ciValueB;
        ramA_q <= ram[addrA];
        ramB_q <= ram[bAddr];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busAddr_q   <= '0;
            memStart_q  <= '0;
            blockSize_q <= '0;
            burst_q     <= '0;
            memRdPend_q <= 1'b0;
        end else begin
            memRdPend_q <= memRdA;
            if (cfgWr) begin
                case (sel)
                    3'd1:    busAddr_q   <= io.ciValueB;
                    3'd2:    memStart_q  <= io.ciValueB[8:0];
                    3'd3:    blockSize_q <= io.ciValueB[9:0];
                    3'd4:    burst_q     <= io.ciValueB[7:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        regRd = '0;
        case (sel)
            3'd1:    regRd = busAddr_q;
            3'd2:    regRd = {23'd0, memStart_q};
            3'd3:    regRd = {22'd0, blockSize_q};
            3'd4:    regRd = {24'd0, burst_q};
            3'd5:    regRd = {30'd0, err_q, busy};
            default: regRd = '0;
        endcase
        io.ciDone   = memRdPend_q || (hit && !memRdA);
        io.ciResult = memRdPend_q ? ramA_q : ((hit && !we && sel != 3'd0) ? regRd : 32'd0);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            curBus_q <= '0; curMem_q <= '0; remain_q <= '0; words_q <= '0; cnt_q <= '0;
            err_q <= 1'b0; dirRd_q <= 1'b0;
            beginOut_q <= 1'b0; endOut_q <= 1'b0; rnwOut_q <= 1'b0; dvOut_q <= 1'b0;
            adOut_q <= '0; beOut_q <= '0; bsOut_q <= '0;
        end else begin
            state_q <= state_d;
            curBus_q <= curBus_d; curMem_q <= curMem_d; remain_q <= remain_d;
            words_q <= words_d; cnt_q <= cnt_d; err_q <= err_d; dirRd_q <= dirRd_d;
            beginOut_q <= beginOut_d; endOut_q <= endOut_d; rnwOut_q <= rnwOut_d;
            dvOut_q <= dvOut_d; adOut_q <= adOut_d; beOut_q <= beOut_d; bsOut_q <= bsOut_d;
        end
    end

    // Bus outputs default to 0 each cycle; only the driving states set them.
    always_comb begin
        state_d = state_q; curBus_d = curBus_q; curMem_d = curMem_q; remain_d = remain_q;
        words_d = words_q; cnt_d = cnt_q; err_d = err_q; dirRd_d = dirRd_q;
        beginOut_d = 1'b0; endOut_d = 1'b0; rnwOut_d = 1'b0; dvOut_d = 1'b0;
        adOut_d = '0; beOut_d = '0; bsOut_d = '0;
        memWrB = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                err_d    = 1'b0;
                dirRd_d  = io.ciValueB[0];
                curBus_d = busAddr_q;
                curMem_d = memStart_q;
                remain_d = blockSize_q;
                if (blockSize_q != 10'd0) state_d = REQUEST;
            end
            REQUEST: if (io.transactionGranted) begin
                state_d    = INIT;
                words_d    = wordsNow;
                beginOut_d = 1'b1;
                adOut_d    = curBus_q;
                beOut_d    = 4'hF;
                rnwOut_d   = dirRd_q;
                bsOut_d    = wm1[7:0];
            end
            INIT: begin
                cnt_d   = '0;
                state_d = dirRd_q ? READ_DATA : WRITE_DATA;
            end
            READ_DATA: begin
                if (io.dataValidIn) begin
                    memWrB   = 1'b1;
                    curMem_d = curMem_q + 9'd1;
                end
                if (io.endTransactionIn) begin
                    remain_d = remain_q - {1'b0, words_q};
                    curBus_d = curBus_q + {21'd0, words_q, 2'b00};
                    state_d  = (remain_q != {1'b0, words_q}) ? REQUEST : IDLE;
                end
            end
            WRITE_DATA: begin
                if (dvOut_q && io.busyIn) begin
                    dvOut_d = 1'b1;
                    adOut_d = adOut_q;
                end else if (cnt_q != words_q) begin
                    dvOut_d  = 1'b1;
                    adOut_d  = ramB_q;
                    cnt_d    = cnt_q + 9'd1;
                    curMem_d = curMem_q + 9'd1;
                end else begin
                    endOut_d = 1'b1;
                    state_d  = WAIT_END;
                end
            end
            WAIT_END: begin
                remain_d = remain_q - {1'b0, words_q};
                curBus_d = curBus_q + {21'd0, words_q, 2'b00};
                state_d  = (remain_q != {1'b0, words_q}) ? REQUEST : IDLE;
            end
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (io.busErrorIn && (state_q inside {INIT, READ_DATA, WRITE_DATA, WAIT_END})) begin
            state_d = ERROR; err_d = 1'b1; memWrB = 1'b0;
            beginOut_d = 1'b0; endOut_d = 1'b0; rnwOut_d = 1'b0; dvOut_d = 1'b0;
            adOut_d = '0; beOut_d = '0; bsOut_d = '0;
        end
    end

    assign io.requestTransaction  = (state_q == REQUEST);
    assign io.beginTransactionOut = beginOut_q;
    assign io.endTransactionOut   = endOut_q;
    assign io.readNotWriteOut     = rnwOut_q;
    assign io.dataValidOut        = dvOut_q;
    assign io.addressDataOut      = adOut_q;
    assign io.byteEnablesOut      = beOut_q;
    assign io.burstSizeOut        = bsOut_q;

    logic unused_bits;
    assign unused_bits = ^{io.ciValueA[31:13], io.beginTransactionIn, io.readNotWriteIn,
                           io.byteEnablesIn, io.burstSizeIn, wm1[8]};
endmodule

// File: tb/tb_ram_dma_ci.sv
// Randomized bench for ram_dma_ci: acts as CPU and bus slave, checks against
// a block-level model of memory contents and expected burst sequences.
module tb_ram_dma_ci;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    ram_dma_ci_if io();
    ram_dma_ci dut (.clock(clk), .reset(rst_n), .io(io));

    int total = 0, bad = 0;
    logic [31:0] mmem [512];
    logic [31:0] m_bus; logic [8:0] m_ms; logic [9:0] m_bs; logic [7:0] m_burst;
    logic [31:0] q_addr[$]; logic [7:0] q_bs[$]; logic [31:0] q_data[$];
    int nb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ci(input logic [7:0] n, input logic [31:0] a, input logic [31:0] b,
                      output logic [31:0] r, output bit d0, output bit d1);
        @(negedge clk);
        io.ciStart = 1'b1; io.ciN = n; io.ciValueA = a; io.ciValueB = b;
        #1; d0 = io.ciDone; r = io.ciResult;
        @(negedge clk);
        io.ciStart = 1'b0;
        #1; d1 = io.ciDone;
        if (d1) r = io.ciResult;
    endtask

    task automatic wr(input logic [2:0] sel, input logic [8:0] a, input logic [31:0] d);
        logic [31:0] r; bit d0, d1;
        ci(8'd12, {19'd0, sel, 1'b1, a}, d, r, d0, d1);
        chk("wr_done", {30'd0, d0, d1}, 32'd2);
        if (sel == 3'd0) mmem[a] = d;
    endtask

    task automatic rd(input logic [2:0] sel, input logic [8:0] a, input logic [31:0] exp, input string tag);
        logic [31:0] r; bit d0, d1;
        ci(8'd12, {19'd0, sel, 1'b0, a}, 32'd0, r, d0, d1);
        chk({tag, "_done"}, {30'd0, d0, d1}, (sel == 3'd0) ? 32'd1 : 32'd2);
        chk(tag, r, exp);
    endtask

    task automatic cfg(input logic [31:0] bus, input logic [8:0] ms, input logic [9:0] bs, input logic [7:0] bu);
        wr(3'd1, 9'd0, bus); wr(3'd2, 9'd0, {23'd0, ms});
        wr(3'd3, 9'd0, {22'd0, bs}); wr(3'd4, 9'd0, {24'd0, bu});
        m_bus = bus; m_ms = ms; m_bs = bs; m_burst = bu;
    endtask

    // Expected bursts derived from block/burst sizes with plain arithmetic.
    task automatic plan();
        int rem, w, k; logic [31:0] a; logic [8:0] ix;
        q_addr.delete(); q_bs.delete(); q_data.delete();
        rem = int'(m_bs); a = m_bus; k = 0; nb = 0;
        while (rem > 0) begin
            w = (int'(m_burst) + 1 < rem) ? int'(m_burst) + 1 : rem;
            q_addr.push_back(a); q_bs.push_back(8'(w - 1));
            for (int j = 0; j < w; j++) begin
                ix = m_ms + 9'(k); q_data.push_back(mmem[ix]); k++;
            end
            a += 32'(4 * w); rem -= w; nb++;
        end
    endtask

    task automatic run_m2b();
        int ends = 0, cyc = 0; bit bz;
        io.transactionGranted = 1'b1;
        while (ends < nb && cyc < 3000) begin
            @(negedge clk); cyc++;
            if (io.beginTransactionOut) begin
                if (q_addr.size() == 0) chk("m2b_extra_begin", 32'd1, 32'd0);
                else begin
                    chk("m2b_addr", io.addressDataOut, q_addr.pop_front());
                    chk("m2b_bs", {24'd0, io.burstSizeOut}, {24'd0, q_bs.pop_front()});
                    chk("m2b_rnw_be", {27'd0, io.readNotWriteOut, io.byteEnablesOut}, 32'h0F);
                end
            end
            if (io.endTransactionOut) ends++;
            bz = ($urandom_range(0, 3) == 0);
            io.busyIn = bz;
            if (io.dataValidOut && !bz) begin
                if (q_data.size() == 0) chk("m2b_extra_data", 32'd1, 32'd0);
                else chk("m2b_data", io.addressDataOut, q_data.pop_front());
            end
        end
        io.busyIn = 1'b0; io.transactionGranted = 1'b0;
        chk("m2b_bursts", ends, nb);
        chk("m2b_words_left", q_data.size(), 32'd0);
    endtask

    task automatic run_b2m(input bit seq);
        int phase = 0, nleft = 0, k = 0, done = 0, cyc = 0;
        logic [31:0] d; logic [8:0] ix;
        io.transactionGranted = 1'b1;
        while (done < nb && cyc < 3000) begin
            @(negedge clk); cyc++;
            io.dataValidIn = 1'b0; io.endTransactionIn = 1'b0;
            case (phase)
                0: if (io.beginTransactionOut) begin
                    if (q_addr.size() == 0) chk("b2m_extra_begin", 32'd1, 32'd0);
                    else begin
                        chk("b2m_addr", io.addressDataOut, q_addr.pop_front());
                        chk("b2m_bs", {24'd0, io.burstSizeOut}, {24'd0, q_bs.pop_front()});
                        chk("b2m_rnw_be", {27'd0, io.readNotWriteOut, io.byteEnablesOut}, 32'h1F);
                    end
                    nleft = int'(io.burstSizeOut) + 1; phase = 1;
                end
                1: if ($urandom_range(0, 2) != 0) begin
                    d = seq ? 32'hA + 32'(k) : $urandom();
                    io.dataValidIn = 1'b1; io.addressDataIn = d;
                    ix = m_ms + 9'(k); mmem[ix] = d; k++; nleft--;
                    if (nleft == 0) phase = 2;
                end
                default: begin io.endTransactionIn = 1'b1; done++; phase = 0; end
            endcase
        end
        @(negedge clk);
        io.endTransactionIn = 1'b0; io.dataValidIn = 1'b0; io.transactionGranted = 1'b0;
        chk("b2m_bursts", done, nb);
    endtask

    task automatic check_mem_block();
        logic [8:0] ix;
        for (int j = 0; j < int'(m_bs); j++) begin
            ix = m_ms + 9'(j); rd(3'd0, ix, mmem[ix], "b2m_mem");
        end
    endtask

    initial begin
        logic [31:0] r; bit d0, d1, found; logic [8:0] ix;
        logic [31:0] rb; logic [8:0] rms; logic [9:0] rbs; logic [7:0] rbu;
        io.ciStart = 0; io.ciN = 0; io.ciValueA = 0; io.ciValueB = 0; io.transactionGranted = 0;
        io.beginTransactionIn = 0; io.endTransactionIn = 0; io.readNotWriteIn = 0;
        io.dataValidIn = 0; io.busyIn = 0; io.busErrorIn = 0;
        io.addressDataIn = 0; io.byteEnablesIn = 0; io.burstSizeIn = 0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", {26'd0, io.ciDone, io.requestTransaction, io.beginTransactionOut,
                        io.endTransactionOut, io.readNotWriteOut, io.dataValidOut}, 32'd0);
        chk("rst_ad", io.addressDataOut, 32'd0);
        chk("rst_be_bs", {20'd0, io.byteEnablesOut, io.burstSizeOut}, 32'd0);
        rst_n = 1'b1;
        for (int s = 1; s <= 5; s++) rd(3'(s), 9'd0, 32'd0, "rst_reg");

        wr(3'd0, 9'd5, 32'hDEADBEEF);
        rd(3'd0, 9'd5, 32'hDEADBEEF, "mem5");
        wr(3'd3, 9'd0, 32'h15); wr(3'd4, 9'd0, 32'h5);
        rd(3'd3, 9'd0, 32'h15, "cfg_bs"); rd(3'd4, 9'd0, 32'h5, "cfg_burst");
        rd(3'd6, 9'd0, 32'd0, "reserved6");

        // Directed memory->bus: 21 words in bursts of 6.
        for (int j = 0; j < 21; j++) wr(3'd0, 9'(j), $urandom());
        cfg(32'h1000, 9'd0, 10'h15, 8'd5);
        plan();
        wr(3'd5, 9'd0, 32'd2);
        rd(3'd5, 9'd0, 32'd1, "busy");
        wr(3'd3, 9'd0, 32'd7);
        rd(3'd3, 9'd0, 32'h15, "cfg_locked");
        run_m2b();
        rd(3'd5, 9'd0, 32'd0, "m2b_idle");

        // Directed bus->memory: three single-word bursts of 0xA, 0xB, 0xC.
        cfg(32'h2000, 9'd0, 10'd3, 8'd0);
        plan();
        wr(3'd5, 9'd0, 32'd1);
        run_b2m(1'b1);
        rd(3'd0, 9'd0, 32'hA, "b2m_w0"); rd(3'd0, 9'd1, 32'hB, "b2m_w1"); rd(3'd0, 9'd2, 32'hC, "b2m_w2");
        rd(3'd5, 9'd0, 32'd0, "b2m_idle");

        // Bus error during a memory->bus burst.
        cfg(32'h3000, 9'd100, 10'd10, 8'd3);
        wr(3'd5, 9'd0, 32'd2);
        io.transactionGranted = 1'b1; found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge clk);
            if (io.dataValidOut) found = 1'b1;
        end
        chk("err_dv_seen", {31'd0, found}, 32'd1);
        io.busErrorIn = 1'b1;
        @(negedge clk);
        io.busErrorIn = 1'b0; io.transactionGranted = 1'b0;
        chk("err_ctl", {27'd0, io.beginTransactionOut, io.endTransactionOut, io.readNotWriteOut,
                        io.dataValidOut, io.requestTransaction}, 32'd0);
        chk("err_ad", io.addressDataOut, 32'd0);
        chk("err_be_bs", {20'd0, io.byteEnablesOut, io.burstSizeOut}, 32'd0);
        rd(3'd5, 9'd0, 32'd2, "err_status");

        // Wrong opcode: ignored entirely.
        ci(8'd11, {19'd0, 3'd3, 1'b1, 9'd0}, 32'h3FF, r, d0, d1);
        chk("wrong_op_done", {30'd0, d0, d1}, 32'd0);
        chk("wrong_op_res", r, 32'd0);
        rd(3'd3, 9'd0, {22'd0, m_bs}, "wrong_op_bs");

        // Block size zero: start produces no bus activity.
        cfg(32'h4000, 9'd0, 10'd0, 8'd0);
        wr(3'd5, 9'd0, 32'd2);
        repeat (3) @(negedge clk);
        chk("blk0_req", {31'd0, io.requestTransaction}, 32'd0);
        rd(3'd5, 9'd0, 32'd0, "blk0_status");

        for (int it = 0; it < 6; it++) begin
            rb = $urandom() & 32'hFFFF_FFFC;
            rms = (it == 0) ? 9'd506 : 9'($urandom_range(0, 511));
            rbs = 10'($urandom_range(1, 24));
            rbu = 8'($urandom_range(0, 7));
            if (it % 2 == 0) begin
                for (int j = 0; j < int'(rbs); j++) begin
                    ix = rms + 9'(j); wr(3'd0, ix, $urandom());
                end
                cfg(rb, rms, rbs, rbu);
                plan();
                wr(3'd5, 9'd0, 32'd2);
                run_m2b();
            end else begin
                cfg(rb, rms, rbs, rbu);
                plan();
                wr(3'd5, 9'd0, 32'd3);
                run_b2m(1'b0);
                check_mem_block();
            end
            rd(3'd5, 9'd0, 32'd0, "rand_idle");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
